// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter and its pick logic.
// Holds FSM state and arbitration mode enums.
package mem_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational winner select over NCH requests.
// Ports: req, start (rr pointer), mode -> winner, valid.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NCH = 2,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  start,
  input  arb_mode_t      mode,
  output logic [IW-1:0]  winner,
  output logic           valid
);

  int base;
  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    base   = 0;
    idx    = 0;
    if (mode == ARB_RR && int'(start) < NCH)
      base = int'(start);
    for (int k = 0; k < NCH; k++) begin
      // explicit wrap: NCH need not be a power of two
      idx = base + k;
      if (idx >= NCH)
        idx = idx - NCH;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: NCH cache channels onto one memory port.
// Ports: ch_* (cache side), ram_* (memory side), CLK, nRST.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int ARB_MODE  = 0,
  parameter int BURST_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [NCH-1:0]    ch_ren,
  input  logic [NCH-1:0]    ch_wen,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_store,
  output logic [NCH-1:0]    ch_wait,
  output logic [DW-1:0]     ch_load,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_store,
  input  logic [DW-1:0]     ram_load,
  input  logic              ram_wait
);

  localparam int IW = $clog2(NCH);
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam arb_mode_t MODE =
    (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  arb_state_t      state;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   burst_cnt;

  logic [NCH-1:0]  req;
  logic [AW-1:0]   addr_a [NCH];
  logic [DW-1:0]   store_a [NCH];
  logic [IW-1:0]   win;
  logic            win_vld;
  logic            g_req;
  logic            done;
  logic            last;
  logic            rel;

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign addr_a[i]  = ch_addr[i*AW +: AW];
    assign store_a[i] = ch_store[i*DW +: DW];
  end

  assign req     = ch_ren | ch_wen;
  assign ch_load = ram_load;

  arb_pick #(
    .NCH (NCH),
    .IW  (IW)
  ) u_pick (
    .req    (req),
    .start  (rr_ptr),
    .mode   (MODE),
    .winner (win),
    .valid  (win_vld)
  );

  assign g_req = req[grant];
  assign done  = (state == GRANT) & g_req & ~ram_wait;
  // the completion that fills the window ends the grant
  assign last  = done & (burst_cnt == CW'(BURST_MAX - 1));
  assign rel   = (state == GRANT) & (~g_req | last);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            grant <= win;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            state     <= IDLE;
            burst_cnt <= '0;
            if (MODE == ARB_RR)
              rr_ptr <= (grant == IW'(NCH - 1)) ?
                        '0 : grant + 1'b1;
          end else if (done &&
                       burst_cnt != CW'(BURST_MAX)) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    ch_wait   = '1;
    if (state == GRANT) begin
      ram_addr  = addr_a[grant];
      ram_store = store_a[grant];
      ram_wen   = ch_wen[grant];
      // ren+wen together: write wins
      ram_ren   = ch_ren[grant] & ~ch_wen[grant];
      ch_wait[grant] = g_req ? ram_wait : 1'b1;
    end
  end

endmodule
